// File: rtl/fp_add_arbiter_if.sv
// Requester, response and adder-side signals of the shared FP16 adder arbiter.
// master = arbiter view; slave = requesters plus the adder instance.
interface fp_add_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic                          add_en;
    logic [DATA_WIDTH-1:0]         add_a;
    logic [DATA_WIDTH-1:0]         add_b;
    logic [DATA_WIDTH-1:0]         add_result;
    logic                          idle;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready, add_result,
        output req_ready, rsp_valid, rsp_data, add_en, add_a, add_b, idle
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready, add_result,
        input  req_ready, rsp_valid, rsp_data, add_en, add_a, add_b, idle
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sharer of one pipelined FP16 adder; results routed back by tag, ADD_LATENCY cycles.
// A head result its requester cannot take freezes the adder and suppresses all grants.
module fp_add_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int ADD_LATENCY   = 4,
    parameter int WARMUP_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    fp_add_arbiter_if.master bus
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int IDX_W = TAG_W + 1;
    localparam int CNT_W = $clog2(WARMUP_CYCLES + 1);

    typedef enum logic {ST_WARMUP = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [ADD_LATENCY-1:0]            v_q, v_d;
    logic [ADD_LATENCY-1:0][TAG_W-1:0] t_q, t_d;
    logic [TAG_W-1:0]                  rr_ptr_q, rr_ptr_d;

    logic               run;
    logic               head_vld;
    logic [TAG_W-1:0]   head_tag;
    logic [NUM_REQ-1:0] head_oh;
    logic               stall;
    logic               advance;
    logic               gnt_vld;
    logic [TAG_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic               take;

    assign run      = (state_q == ST_RUN);
    assign head_vld = v_q[ADD_LATENCY-1];
    assign head_tag = t_q[ADD_LATENCY-1];

    always_comb begin
        head_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            head_oh[j] = head_vld && (head_tag == TAG_W'(j));
        end
    end

    assign stall   = |(head_oh & ~bus.rsp_ready);
    assign advance = ~stall;
    assign take    = run && advance && gnt_vld;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WARMUP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: warm-up flushes the adder with zeros before any grant
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_WARMUP) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Search from rr_ptr upward, wrapping, for the first valid requester
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + IDX_W'(k);
            if (scan_idx >= IDX_W'(NUM_REQ)) begin
                scan_idx = scan_idx - IDX_W'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!gnt_vld && bus.req_valid[j] && (scan_idx == IDX_W'(j))) begin
                    gnt_vld = 1'b1;
                    gnt_idx = TAG_W'(j);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q      <= '0;
            t_q      <= '0;
            rr_ptr_q <= '0;
        end else begin
            v_q      <= v_d;
            t_q      <= t_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Shadow pipeline moves in lockstep with the adder enable
    always_comb begin
        v_d      = v_q;
        t_d      = t_q;
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            v_d[0] = take;
            t_d[0] = gnt_idx;
            for (int k = 1; k < ADD_LATENCY; k++) begin
                v_d[k] = v_q[k-1];
                t_d[k] = t_q[k-1];
            end
        end
        if (take) begin
            rr_ptr_d = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
        end
    end

    // Outputs
    always_comb begin
        bus.req_ready = '0;
        bus.add_a     = '0;
        bus.add_b     = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (take && (gnt_idx == TAG_W'(j))) begin
                bus.req_ready[j] = 1'b1;
                bus.add_a        = bus.req_a[j*DATA_WIDTH +: DATA_WIDTH];
                bus.add_b        = bus.req_b[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        bus.add_en    = run ? advance : 1'b1;
        bus.rsp_valid = head_oh;
        bus.rsp_data  = bus.add_result;
        bus.idle      = run && (v_q == '0);
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter with a behavioural 4-stage FP16 adder and a tag/data scoreboard.
module tb_fp_add_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int LAT = 4;
    localparam int WU  = 5;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fp_add_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fp_add_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADD_LATENCY(LAT), .WARMUP_CYCLES(WU)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Positive-normal FP16 add, truncating; operands stay in a range where it is exact enough
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] hi, lo;
        logic [4:0]  d, e;
        logic [11:0] mh, ml, s;
        if (a[14:0] == 15'd0) return b;
        if (b[14:0] == 15'd0) return a;
        if (a[14:10] >= b[14:10]) begin hi = a; lo = b; end
        else begin hi = b; lo = a; end
        d  = hi[14:10] - lo[14:10];
        mh = {2'b01, hi[9:0]};
        ml = {2'b01, lo[9:0]} >> d;
        s  = mh + ml;
        e  = hi[14:10];
        if (s[11]) begin s = s >> 1; e = e + 5'd1; end
        return {1'b0, e, s[9:0]};
    endfunction

    logic [DW-1:0] add_pipe [LAT];
    always @(posedge clk) begin
        if (bus.add_en) begin
            add_pipe[0] <= fp16_add(bus.add_a, bus.add_b);
            for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
        end
    end
    assign bus.add_result = add_pipe[LAT-1];

    typedef struct packed {
        logic [1:0]  tag;
        logic [15:0] dat;
    } exp_t;

    exp_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;
    int   last_gnt = NR - 1;
    int   grants   = 0;
    int   retired  = 0;
    int   mon_tag;

    // Response check and accept capture, both on the falling edge
    always @(negedge clk) begin
        if (bus.rsp_valid != '0) begin
            mon_tag = 0;
            for (int j = 0; j < NR; j++) if (bus.rsp_valid[j]) mon_tag = j;
            checks++;
            if (!$onehot(bus.rsp_valid)) begin
                failures++;
                $display("FAIL rsp_onehot: rsp_valid=%b, required a single bit", bus.rsp_valid);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, required no response", bus.rsp_valid, bus.rsp_data);
            end else begin
                if (mon_tag != int'(exp_q[0].tag) || bus.rsp_data !== exp_q[0].dat) begin
                    failures++;
                    $display("FAIL rsp_scoreboard: tag=%0d data=%h, required tag=%0d data=%h",
                             mon_tag, bus.rsp_data, exp_q[0].tag, exp_q[0].dat);
                end
                if (bus.rsp_ready[mon_tag]) begin
                    void'(exp_q.pop_front());
                    retired++;
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (bus.req_ready[i]) begin
                checks++;
                if (!bus.req_valid[i]) begin
                    failures++;
                    $display("FAIL ready_without_valid: req_ready=%b req_valid=%b", bus.req_ready, bus.req_valid);
                end
                exp_q.push_back({2'(i), fp16_add(bus.req_a[i*DW +: DW], bus.req_b[i*DW +: DW])});
                last_gnt = i;
                grants++;
            end
        end
    end

    function automatic logic [15:0] rand_op();
        return {1'b0, 5'($urandom_range(20, 10)), 10'($urandom)};
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] vld, input int ptr);
        for (int k = 0; k < NR; k++) if (vld[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*DW +: DW] = rand_op();
            bus.req_b[i*DW +: DW] = rand_op();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.req_valid = '0;
        do begin tick(); n++; end while (!bus.idle && n < 40);
        checks++;
        if (!bus.idle || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: idle=%b outstanding=%0d, required idle=1 outstanding=0", name, bus.idle, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        rand_ops();
        repeat (2) tick();
        @(negedge clk);
        checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL reset_req_ready: %b, required 0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== '0) begin failures++; $display("FAIL reset_rsp_valid: %b, required 0", bus.rsp_valid); end
        checks++; if (bus.add_en !== 1'b1) begin failures++; $display("FAIL reset_add_en: %b, required 1", bus.add_en); end
        checks++; if ({bus.add_a, bus.add_b} !== '0) begin failures++; $display("FAIL reset_operands: %h %h, required 0 0", bus.add_a, bus.add_b); end
        checks++; if (bus.idle !== 1'b0) begin failures++; $display("FAIL reset_idle: %b, required 0", bus.idle); end
        checks++; if (bus.rsp_data !== bus.add_result) begin failures++; $display("FAIL reset_rsp_data: %h, required add_result %h", bus.rsp_data, bus.add_result); end
    endtask

    task automatic test_warmup();
        bus.req_valid = 4'b0001;
        tick();
        reset_n = 1'b1;
        for (int c = 1; c <= WU; c++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== '0 || bus.add_en !== 1'b1 || bus.add_a !== '0) begin
                failures++;
                $display("FAIL warmup_cycle%0d: req_ready=%b add_en=%b add_a=%h, required 0000 1 0000", c, bus.req_ready, bus.add_en, bus.add_a);
            end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL warmup_first_grant: %b, required 0001", bus.req_ready); end
        checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL warmup_idle_run: %b, required 1", bus.idle); end
        checks++; if (bus.add_a !== bus.req_a[DW-1:0]) begin failures++; $display("FAIL warmup_add_a: %h, required %h", bus.add_a, bus.req_a[DW-1:0]); end
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if (bus.idle !== 1'b0) begin failures++; $display("FAIL warmup_busy: idle=%b, required 0", bus.idle); end
        drain("warmup");
    endtask

    task automatic test_single();
        int lat;
        bit ok;
        ok = 1'b0;
        bus.req_a[1*DW +: DW] = 16'h3C00;
        bus.req_b[1*DW +: DW] = 16'h4000;
        bus.req_valid         = 4'b0010;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clk);
            if (bus.req_ready[1]) ok = 1'b1;
            else tick();
        end
        checks++; if (!ok) begin failures++; $display("FAIL single_grant: req_ready=%b, required 0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (bus.rsp_valid == '0 && lat < 20);
        checks++; if (lat != LAT) begin failures++; $display("FAIL single_latency: %0d cycles, required %0d", lat, LAT); end
        checks++; if (bus.rsp_valid !== 4'b0010) begin failures++; $display("FAIL single_tag: rsp_valid=%b, required 0010", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 16'h4200) begin failures++; $display("FAIL single_data: %h, required 4200", bus.rsp_data); end
        tick();
        checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL single_idle: %b, required 1", bus.idle); end
    endtask

    task automatic test_round_robin();
        int exp_g;
        int seen2;
        seen2 = 0;
        bus.rsp_ready = '1;
        rand_ops();
        bus.req_a[2*DW +: DW] = 16'h3E00;
        bus.req_b[2*DW +: DW] = 16'h3C00;
        bus.req_valid = '1;
        for (int c = 0; c < 16; c++) begin
            exp_g = (last_gnt + 1) % NR;
            @(negedge clk);
            if (c < 8) begin
                checks++;
                if (bus.req_ready !== NR'(1 << exp_g)) begin
                    failures++;
                    $display("FAIL rr_grant%0d: req_ready=%b, required one-hot %0d", c, bus.req_ready, exp_g);
                end
            end
            if (bus.rsp_valid[2]) begin
                seen2++;
                checks++;
                if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 16'h4100) begin
                    failures++;
                    $display("FAIL rr_req2_result: rsp_valid=%b data=%h, required 0100 4100", bus.rsp_valid, bus.rsp_data);
                end
            end
            tick();
            if (c == 7) bus.req_valid = '0;
        end
        checks++; if (seen2 != 2) begin failures++; $display("FAIL rr_req2_count: %0d results, required 2", seen2); end
        drain("rr");
    endtask

    task automatic test_backpressure();
        int stall;
        logic [DW-1:0] held;
        stall = 0;
        held  = '0;
        rand_ops();
        bus.rsp_ready = 4'b0111;
        bus.req_valid = '1;
        for (int c = 0; c < 40 && stall < 3; c++) begin
            @(negedge clk);
            if (bus.rsp_valid[3]) begin
                stall++;
                checks++;
                if (bus.add_en !== 1'b0 || bus.req_ready !== '0) begin
                    failures++;
                    $display("FAIL bp_freeze%0d: add_en=%b req_ready=%b, required 0 0000", stall, bus.add_en, bus.req_ready);
                end
                if (stall == 1) held = bus.rsp_data;
                else begin
                    checks++;
                    if (bus.rsp_data !== held) begin failures++; $display("FAIL bp_data_hold%0d: %h, required %h", stall, bus.rsp_data, held); end
                end
            end
            tick();
        end
        checks++; if (stall != 3) begin failures++; $display("FAIL bp_stall_seen: %0d stall cycles, required 3", stall); end
        bus.rsp_ready = '1;
        @(negedge clk);
        checks++;
        if (bus.add_en !== 1'b1 || bus.rsp_valid !== 4'b1000 || bus.rsp_data !== held) begin
            failures++;
            $display("FAIL bp_release: add_en=%b rsp_valid=%b data=%h, required 1 1000 %h", bus.add_en, bus.rsp_valid, bus.rsp_data, held);
        end
        tick();
        drain("bp");
    endtask

    task automatic test_wrap();
        int exp_g;
        logic [NR-1:0] prev_rdy;
        prev_rdy = '0;
        bus.rsp_ready = '1;
        bus.req_valid = 4'b1001;
        for (int c = 0; c < 6; c++) begin
            exp_g = rr_pick(4'b1001, (last_gnt + 1) % NR);
            @(negedge clk);
            checks++;
            if (bus.req_ready !== NR'(1 << exp_g)) begin
                failures++;
                $display("FAIL wrap_grant%0d: req_ready=%b, required one-hot %0d", c, bus.req_ready, exp_g);
            end
            if (c > 0) begin
                checks++;
                if (bus.req_ready === prev_rdy) begin failures++; $display("FAIL wrap_alternate%0d: req_ready=%b repeated", c, bus.req_ready); end
            end
            prev_rdy = bus.req_ready;
            tick();
            rand_ops();
        end
        drain("wrap");
    endtask

    task automatic test_midflight_reset();
        int g0;
        g0 = grants;
        rand_ops();
        bus.rsp_ready = '1;
        bus.req_valid = 4'b0111;
        repeat (3) tick();
        bus.req_valid = '0;
        tick();
        checks++; if (grants - g0 != 3) begin failures++; $display("FAIL mid_inflight: %0d grants, required 3", grants - g0); end
        checks++; if (bus.rsp_valid == '0) begin failures++; $display("FAIL mid_head: rsp_valid=%b, required nonzero", bus.rsp_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== '0) begin failures++; $display("FAIL mid_rsp_drop: %b, required 0", bus.rsp_valid); end
        checks++; if (bus.add_en !== 1'b1) begin failures++; $display("FAIL mid_add_en: %b, required 1", bus.add_en); end
        exp_q.delete();
        last_gnt = NR - 1;
        bus.req_valid = '1;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int c = 1; c <= WU; c++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== '0 || bus.rsp_valid !== '0) begin
                failures++;
                $display("FAIL mid_warmup%0d: req_ready=%b rsp_valid=%b, required 0000 0000", c, bus.req_ready, bus.rsp_valid);
            end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_grant: %b, required 0001", bus.req_ready); end
        tick();
        drain("mid");
    endtask

    task automatic test_back_to_back();
        int g0, r0;
        g0 = grants;
        r0 = retired;
        bus.rsp_ready = '1;
        rand_ops();
        bus.req_valid = '1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (!$onehot(bus.req_ready)) begin failures++; $display("FAIL b2b_grant%0d: req_ready=%b, required one-hot", c, bus.req_ready); end
            if (c >= LAT) begin
                checks++;
                if (bus.rsp_valid == '0) begin failures++; $display("FAIL b2b_rsp%0d: rsp_valid=%b, required nonzero", c, bus.rsp_valid); end
            end
            tick();
            rand_ops();
        end
        drain("b2b");
        checks++; if (grants - g0 != 20) begin failures++; $display("FAIL b2b_grants: %0d, required 20", grants - g0); end
        checks++; if (retired - r0 != 20) begin failures++; $display("FAIL b2b_retired: %0d, required 20", retired - r0); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;
        test_reset();
        test_warmup();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_midflight_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
